// File: rtl/ysyx_22050612_ifetch_pkg.sv
// Package for the instruction fetch controller.
// Contents: FSM state type, alignment constant, fault instruction value
// and a helper that selects one 32-bit word out of a 64-bit doubleword.
package ysyx_22050612_ifetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP,
    S_DROP
  } state_t;

  localparam int unsigned IFETCH_ALIGN_BITS = 3;
  localparam logic [31:0] INST_FAULT_VAL    = 32'h0;

  // pc[2] chooses the upper or lower instruction of the doubleword
  function automatic logic [31:0] pick_word(input logic [63:0] dw, input logic hi);
    return hi ? dw[63:32] : dw[31:0];
  endfunction

endpackage

// File: rtl/ysyx_22050612_ifetch_if.sv
// Bundle of the fetch controller's core-side and memory-side signals.
// Modports:
//   master - the fetch controller (drives inst_*, fault_o, mem_req, mem_addr)
//   slave  - the surrounding core/memory (drives pc_*, flush, inst_ready, mem_gnt/rvalid/rdata/err)
interface ysyx_22050612_ifetch_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  // core side
  logic [ADDR_W-1:0] pc_i;
  logic              pc_valid;
  logic              flush;
  logic [31:0]       inst_o;
  logic              inst_valid;
  logic              inst_ready;
  logic              fault_o;
  // memory side
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_err;

  modport master (
    input  pc_i, pc_valid, flush, inst_ready,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err,
    output inst_o, inst_valid, fault_o, mem_req, mem_addr
  );

  modport slave (
    output pc_i, pc_valid, flush, inst_ready,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err,
    input  inst_o, inst_valid, fault_o, mem_req, mem_addr
  );

endinterface

// File: rtl/ysyx_22050612_ifetch_linebuf.sv
// One-entry line buffer for the fetch controller.
// Holds the tag (address above the doubleword offset) and data of the last
// successful memory response. Used only when YSYX_22050612_IFETCH_LINEBUF_EN
// is defined.
// Ports: clk, rst (sync active-low), lookup_tag -> hit/hit_data,
//        fill/fill_tag/fill_data write the entry, inval clears it
//        (inval wins over fill).
module ysyx_22050612_ifetch_linebuf #(
  parameter int unsigned TAG_W  = 61,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data,
  input  logic              fill,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              inval
);

  logic              valid;
  logic [TAG_W-1:0]  tag;
  logic [DATA_W-1:0] data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (inval) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      data  <= fill_data;
    end
  end

  assign hit      = valid && (tag == lookup_tag);
  assign hit_data = data;

endmodule

// File: rtl/ysyx_22050612_ifetch.sv
// Instruction fetch controller between the core's pc output and inst input.
// Accepts a fetch address, runs req/gnt/rvalid to a 64-bit instruction
// memory, selects the 32-bit instruction and hands it to the core with a
// valid/ready handshake. Supports flush and fault reporting (misaligned pc
// or memory error). All outputs are registered.
// Ports: clk, rst (synchronous, active-low), bus (ysyx_22050612_ifetch_if.master).
// Optional: define YSYX_22050612_IFETCH_LINEBUF_EN to add a one-entry line
// buffer that serves repeat fetches from the same doubleword in one cycle.
module ysyx_22050612_ifetch
  import ysyx_22050612_ifetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic clk,
  input  logic rst,
  ysyx_22050612_ifetch_if.master bus
);

  state_t            state;
  logic              word_sel;   // pc[2] of the fetch in flight
  logic              lb_hit;
  logic [DATA_W-1:0] lb_data;
  logic              misaligned;
  logic [ADDR_W-1:0] line_addr;

  assign misaligned = |bus.pc_i[1:0];
  assign line_addr  = {bus.pc_i[ADDR_W-1:IFETCH_ALIGN_BITS], {IFETCH_ALIGN_BITS{1'b0}}};

`ifdef YSYX_22050612_IFETCH_LINEBUF_EN
  logic lb_fill;
  logic lb_inval;

  // A flushed or errored response must never populate the buffer
  assign lb_inval = bus.flush || (state == S_WAIT && bus.mem_rvalid && bus.mem_err);
  assign lb_fill  = (state == S_WAIT) && bus.mem_rvalid && !bus.mem_err && !bus.flush;

  ysyx_22050612_ifetch_linebuf #(
    .TAG_W  (ADDR_W - IFETCH_ALIGN_BITS),
    .DATA_W (DATA_W)
  ) u_linebuf (
    .clk        (clk),
    .rst        (rst),
    .lookup_tag (bus.pc_i[ADDR_W-1:IFETCH_ALIGN_BITS]),
    .hit        (lb_hit),
    .hit_data   (lb_data),
    .fill       (lb_fill),
    .fill_tag   (bus.mem_addr[ADDR_W-1:IFETCH_ALIGN_BITS]),
    .fill_data  (bus.mem_rdata),
    .inval      (lb_inval)
  );
`else
  assign lb_hit  = 1'b0;
  assign lb_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      word_sel       <= 1'b0;
      bus.mem_req    <= 1'b0;
      bus.mem_addr   <= '0;
      bus.inst_valid <= 1'b0;
      bus.inst_o     <= '0;
      bus.fault_o    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!bus.flush && bus.pc_valid) begin
            word_sel <= bus.pc_i[2];
            if (misaligned) begin
              bus.inst_o     <= INST_FAULT_VAL;
              bus.fault_o    <= 1'b1;
              bus.inst_valid <= 1'b1;
              state          <= S_RESP;
            end else if (lb_hit) begin
              bus.inst_o     <= pick_word(lb_data, bus.pc_i[2]);
              bus.fault_o    <= 1'b0;
              bus.inst_valid <= 1'b1;
              state          <= S_RESP;
            end else begin
              bus.mem_req  <= 1'b1;
              bus.mem_addr <= line_addr;
              state        <= S_REQ;
            end
          end
        end

        S_REQ: begin
          // A granted request is outstanding even when flushed, so it must be drained
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            state       <= bus.flush ? S_DROP : S_WAIT;
          end else if (bus.flush) begin
            bus.mem_req <= 1'b0;
            state       <= S_IDLE;
          end
        end

        S_WAIT: begin
          if (bus.mem_rvalid) begin
            if (bus.flush) begin
              state <= S_IDLE;
            end else if (bus.mem_err) begin
              bus.inst_o     <= INST_FAULT_VAL;
              bus.fault_o    <= 1'b1;
              bus.inst_valid <= 1'b1;
              state          <= S_RESP;
            end else begin
              bus.inst_o     <= pick_word(bus.mem_rdata, word_sel);
              bus.fault_o    <= 1'b0;
              bus.inst_valid <= 1'b1;
              state          <= S_RESP;
            end
          end else if (bus.flush) begin
            state <= S_DROP;
          end
        end

        S_RESP: begin
          if (bus.flush || bus.inst_ready) begin
            bus.inst_valid <= 1'b0;
            state          <= S_IDLE;
          end
        end

        S_DROP: begin
          if (bus.mem_rvalid) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_ifetch.sv
// Self-checking bench for ysyx_22050612_ifetch. Inputs change and outputs are
// sampled on the falling clock edge. Expected results come from a small
// behavioural model: a misaligned pc faults, a line-buffer hit (when the
// optional buffer is built) returns the remembered doubleword's half,
// everything else goes to memory exactly once.
module tb_ysyx_22050612_ifetch;

`ifdef YSYX_22050612_IFETCH_LINEBUF_EN
  localparam bit LB_EN = 1'b1;
`else
  localparam bit LB_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  ysyx_22050612_ifetch_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  ysyx_22050612_ifetch #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // number of accepted memory requests (req && gnt at a rising edge)
  int hs_cnt = 0;
  always @(posedge clk) begin
    if (rst && bus.mem_req && bus.mem_gnt) hs_cnt <= hs_cnt + 1;
  end

  // reference model of the line buffer contents
  bit          m_lb_v = 1'b0;
  logic [60:0] m_lb_tag;
  logic [63:0] m_lb_d;

  // One complete fetch. gd: cycles gnt is held low, rd: cycles between grant
  // and rvalid, err: response error, qd: cycles inst_ready is held low.
  task automatic do_fetch(input logic [63:0] pc, input logic [63:0] data,
                          input int unsigned gd, input int unsigned rd,
                          input bit err, input int unsigned qd);
    int          hs0;
    bit          need_mem;
    logic [31:0] exp_inst;
    bit          exp_fault;
    logic [63:0] exp_addr;
    logic [33:0] held;
    hs0      = hs_cnt;
    exp_addr = {pc[63:3], 3'b000};
    bus.pc_i     = pc;
    bus.pc_valid = 1'b1;
    @(negedge clk);
    bus.pc_valid = 1'b0;
    bus.pc_i     = {$urandom, $urandom};
    need_mem  = 1'b0;
    exp_inst  = 32'h0;
    exp_fault = 1'b0;
    if (pc[1:0] != 2'b00) begin
      exp_fault = 1'b1;
    end else if (LB_EN && m_lb_v && m_lb_tag == pc[63:3]) begin
      exp_inst = pc[2] ? m_lb_d[63:32] : m_lb_d[31:0];
    end else begin
      need_mem = 1'b1;
    end

    if (need_mem) begin
      for (int unsigned i = 0; i <= gd; i++) begin
        n_total++;
        if ({bus.mem_req, bus.inst_valid, bus.mem_addr} !== {1'b1, 1'b0, exp_addr}) begin
          $display("FAIL req_hold pc=%h cyc=%0d got req=%b v=%b addr=%h exp req=1 v=0 addr=%h",
                   pc, i, bus.mem_req, bus.inst_valid, bus.mem_addr, exp_addr);
        end else n_pass++;
        if (i == gd) bus.mem_gnt = 1'b1;
        @(negedge clk);
      end
      bus.mem_gnt = 1'b0;
      repeat (rd) @(negedge clk);
      n_total++;
      if ({bus.mem_req, bus.inst_valid} !== 2'b00) begin
        $display("FAIL wait_idle pc=%h got req=%b v=%b exp req=0 v=0", pc, bus.mem_req, bus.inst_valid);
      end else n_pass++;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = data;
      bus.mem_err    = err;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      bus.mem_err    = 1'b0;
      bus.mem_rdata  = {$urandom, $urandom};
      if (err) begin
        exp_fault = 1'b1;
        m_lb_v    = 1'b0;
      end else begin
        exp_inst = pc[2] ? data[63:32] : data[31:0];
        m_lb_v   = 1'b1;
        m_lb_tag = pc[63:3];
        m_lb_d   = data;
      end
    end

    for (int unsigned i = 0; i <= qd; i++) begin
      n_total++;
      held = {bus.inst_valid, bus.fault_o, bus.inst_o};
      if (held !== {1'b1, exp_fault, exp_inst}) begin
        $display("FAIL resp pc=%h cyc=%0d got v=%b f=%b inst=%h exp v=1 f=%b inst=%h",
                 pc, i, bus.inst_valid, bus.fault_o, bus.inst_o, exp_fault, exp_inst);
      end else n_pass++;
      if (i == qd) bus.inst_ready = 1'b1;
      @(negedge clk);
    end
    bus.inst_ready = 1'b0;
    n_total++;
    if (bus.inst_valid !== 1'b0) begin
      $display("FAIL resp_drop pc=%h got v=%b exp v=0", pc, bus.inst_valid);
    end else n_pass++;
    n_total++;
    if (hs_cnt - hs0 != (need_mem ? 1 : 0)) begin
      $display("FAIL req_count pc=%h got %0d exp %0d", pc, hs_cnt - hs0, need_mem ? 1 : 0);
    end else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.pc_valid = 1'b1;
    bus.pc_i     = 64'h8000_0000;
    repeat (3) @(negedge clk);
    n_total++;
    if ({bus.mem_req, bus.mem_addr, bus.inst_valid, bus.inst_o, bus.fault_o} !== '0) begin
      $display("FAIL reset_vals got req=%b addr=%h v=%b inst=%h f=%b exp all zero",
               bus.mem_req, bus.mem_addr, bus.inst_valid, bus.inst_o, bus.fault_o);
    end else n_pass++;
    bus.pc_valid = 1'b0;
    rst = 1'b1;
    m_lb_v = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_fetch(64'h8000_0004, 64'h00500093_00000413, 0, 0, 1'b0, 0);
    n_total++;
    if (bus.inst_o !== 32'h00500093) begin
      $display("FAIL basic_inst got %h exp 00500093", bus.inst_o);
    end else n_pass++;
  endtask

  task automatic test_misaligned();
    do_fetch(64'h8000_0002, 64'h0, 0, 0, 1'b0, 0);
    do_fetch(64'h8000_0007, 64'h0, 0, 0, 1'b0, 2);
  endtask

  task automatic test_stall();
    do_fetch(64'h8000_0010, {$urandom, $urandom}, 4, 1, 1'b0, 3);
  endtask

  task automatic test_flush_wait();
    int hs0;
    hs0 = hs_cnt;
    bus.pc_i = 64'h8000_0018; bus.pc_valid = 1'b1;
    @(negedge clk);
    bus.pc_valid = 1'b0; bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0; bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    m_lb_v = 1'b0;
    @(negedge clk);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    repeat (2) begin
      n_total++;
      if ({bus.inst_valid, bus.mem_req} !== 2'b00) begin
        $display("FAIL flush_wait_quiet got v=%b req=%b exp v=0 req=0", bus.inst_valid, bus.mem_req);
      end else n_pass++;
      @(negedge clk);
    end
    n_total++;
    if (hs_cnt - hs0 != 1) begin
      $display("FAIL flush_wait_hs got %0d exp 1", hs_cnt - hs0);
    end else n_pass++;
    do_fetch(64'h8000_0008, {$urandom, $urandom}, 0, 0, 1'b0, 0);
  endtask

  task automatic test_flush_other();
    // flush in REQ without grant: request withdrawn
    bus.pc_i = 64'h8000_0040; bus.pc_valid = 1'b1;
    @(negedge clk);
    bus.pc_valid = 1'b0; bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; m_lb_v = 1'b0;
    n_total++;
    if ({bus.mem_req, bus.inst_valid} !== 2'b00) begin
      $display("FAIL flush_req got req=%b v=%b exp 0 0", bus.mem_req, bus.inst_valid);
    end else n_pass++;
    // flush in REQ together with grant: response drained, never presented
    bus.pc_i = 64'h8000_0048; bus.pc_valid = 1'b1;
    @(negedge clk);
    bus.pc_valid = 1'b0; bus.flush = 1'b1; bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bus.mem_req, bus.inst_valid} !== 2'b00) begin
      $display("FAIL flush_gnt got req=%b v=%b exp 0 0", bus.mem_req, bus.inst_valid);
    end else n_pass++;
    // flush in WAIT with same-cycle rvalid: response discarded
    bus.pc_i = 64'h8000_0050; bus.pc_valid = 1'b1;
    @(negedge clk);
    bus.pc_valid = 1'b0; bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.flush = 1'b1;
    bus.mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    bus.mem_rvalid = 1'b0; bus.flush = 1'b0;
    n_total++;
    if (bus.inst_valid !== 1'b0) begin
      $display("FAIL flush_rvalid got v=%b exp 0", bus.inst_valid);
    end else n_pass++;
    // flush in RESP: valid drops without a handshake
    bus.pc_i = 64'h8000_0001; bus.pc_valid = 1'b1;
    @(negedge clk);
    bus.pc_valid = 1'b0; bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n_total++;
    if (bus.inst_valid !== 1'b0) begin
      $display("FAIL flush_resp got v=%b exp 0", bus.inst_valid);
    end else n_pass++;
    // flush in IDLE beats a same-cycle pc_valid
    bus.pc_i = 64'h8000_0003; bus.pc_valid = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    bus.pc_valid = 1'b0; bus.flush = 1'b0;
    n_total++;
    if ({bus.mem_req, bus.inst_valid} !== 2'b00) begin
      $display("FAIL flush_idle got req=%b v=%b exp 0 0", bus.mem_req, bus.inst_valid);
    end else n_pass++;
    do_fetch(64'h8000_0048, {$urandom, $urandom}, 1, 2, 1'b0, 0);
  endtask

  task automatic test_mem_err();
    do_fetch(64'h8000_0020, {$urandom, $urandom}, 0, 1, 1'b1, 1);
    do_fetch(64'h8000_0020, {$urandom, $urandom}, 0, 0, 1'b0, 0);
  endtask

  task automatic test_linebuf();
    do_fetch(64'h8000_0000, {$urandom, $urandom}, 0, 0, 1'b0, 0);
    do_fetch(64'h8000_0004, {$urandom, $urandom}, 0, 0, 1'b0, 0);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    m_lb_v = 1'b0;
    do_fetch(64'h8000_0004, {$urandom, $urandom}, 0, 0, 1'b0, 0);
  endtask

  task automatic test_reset_midfetch();
    bus.pc_i = 64'h8000_0060; bus.pc_valid = 1'b1;
    @(negedge clk);
    bus.pc_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; m_lb_v = 1'b0;
    n_total++;
    if ({bus.mem_req, bus.inst_valid, bus.mem_addr} !== '0) begin
      $display("FAIL reset_mid got req=%b v=%b addr=%h exp all zero", bus.mem_req, bus.inst_valid, bus.mem_addr);
    end else n_pass++;
    do_fetch(64'h8000_0060, {$urandom, $urandom}, 0, 0, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [63:0] pc;
    for (int i = 0; i < 30; i++) begin
      pc = 64'h8000_0000 + 64'($urandom_range(0, 7) << 2);
      if ($urandom_range(0, 7) == 0) pc = pc + 64'($urandom_range(1, 3));
      do_fetch(pc, {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 7) == 0, $urandom_range(0, 2));
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.pc_i = '0; bus.pc_valid = 1'b0; bus.flush = 1'b0; bus.inst_ready = 1'b0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_err = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_misaligned();
    test_stall();
    test_flush_wait();
    test_flush_other();
    test_mem_err();
    test_linebuf();
    test_reset_midfetch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ysyx_22050612_ifetch.md
# ysyx_22050612_ifetch

Instruction fetch controller sitting directly upstream of the `ysyx_22050612_npc` core, between the core's `pc` output and its `inst` input. Accepts a fetch address from the core, runs a request/grant/response handshake to a 64-bit instruction memory port, and selects the 32-bit instruction from the returned doubleword. Presents the result to the core with a valid/ready handshake and supports flush and access-fault reporting.

## Interface
Parameters:
- `ADDR_W`, 64, fetch address width
- `DATA_W`, 64, memory data width; fixed at 64 in this revision

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-low reset
- `pc_i`  in  64  fetch address from IFU
- `pc_valid`  in  1  core requests a fetch of `pc_i`
- `flush`  in  1  discard any outstanding fetch; invalidate line buffer
- `inst_o`  out  32  fetched instruction
- `inst_valid`  out  1  `inst_o`/`fault_o` valid
- `inst_ready`  in  1  core accepts `inst_o`
- `fault_o`  out  1  fetch fault: misaligned `pc_i` or memory error
- `mem_req`  out  1  memory request
- `mem_addr`  out  64  doubleword-aligned address `{pc[63:3],3'b000}`
- `mem_gnt`  in  1  memory accepts request this cycle
- `mem_rvalid`  in  1  response data valid
- `mem_rdata`  in  64  response doubleword
- `mem_err`  in  1  response is an access error; qualified by `mem_rvalid`

## Operation
- FSM states: IDLE, REQ, WAIT, RESP, DROP.
- IDLE: on `pc_valid`, capture `pc_i` into `pc_q`.
  - If `pc_i[1:0]!=0`: go to RESP with `fault_o=1`, `inst_o=0`. No memory request is issued.
  - If a line-buffer hit occurs (see Configuration): go to RESP with the buffered word.
  - Otherwise go to REQ.
  - `pc_valid` is ignored in every state other than IDLE.
- REQ: `mem_req=1`; `mem_addr` stays stable until `mem_gnt`. On `mem_gnt`, go to WAIT.
- WAIT: on `mem_rvalid`:
  - `mem_err=1`: go to RESP with `fault_o=1`, `inst_o=0`; line buffer not written.
  - Otherwise: `inst_o = pc_q[2] ? mem_rdata[63:32] : mem_rdata[31:0]`; go to RESP.
- RESP: `inst_valid=1`; `inst_o`/`fault_o` are held stable until `inst_ready`, then go to IDLE.
- Flush (highest priority in every state):
  - REQ without `mem_gnt`: go to IDLE; `mem_req` drops next cycle.
  - REQ with `mem_gnt` in the same cycle, or WAIT without `mem_rvalid`: go to DROP.
  - WAIT with `mem_rvalid` in the same cycle: response discarded; go to IDLE.
  - RESP: go to IDLE; `inst_valid` deasserts next cycle with no handshake.
  - IDLE: a same-cycle `pc_valid` is ignored.
- DROP: wait for `mem_rvalid`, discard the data, go to IDLE. Only one outstanding request exists at any time.

## Timing
- Reset values (`rst==0` at a clock edge): state IDLE, `mem_req=0`, `mem_addr=0`, `inst_valid=0`, `inst_o=0`, `fault_o=0`, line buffer invalid.
- All outputs are registered.
- Miss with zero-wait memory: `pc_valid` at cycle 0 → `mem_req` at cycle 1 (`gnt` same cycle) → `rvalid` at cycle 2 → `inst_valid` at cycle 3.
- Line-buffer hit or misaligned `pc_i`: `inst_valid` at cycle 1.
- Throughput: with `inst_ready` held high, a new `pc_valid` is accepted in the cycle after the RESP handshake.
- Reset asserted mid-fetch returns to IDLE immediately. A memory response still in flight afterwards is the memory's responsibility; system reset covers both.

## Configuration
- `YSYX_22050612_IFETCH_LINEBUF_EN` defined: a one-entry line buffer holds the tag `pc[63:3]` and the 64-bit data of the last successful response.
  - An IDLE fetch whose tag matches takes the hit path.
  - Invalidated by `flush`, by `mem_err`, and by reset.
- Not defined: no buffer; every aligned fetch goes through REQ.

## Structure
- Package `ysyx_22050612_ifetch_pkg` holds:
  - FSM state enum
  - `IFETCH_ALIGN_BITS=3`
  - `INST_FAULT_VAL=32'h0`
- Sub-module `ysyx_22050612_ifetch_linebuf`: tag/data/valid registers, hit compare, and fill/invalidate ports. Instantiated only under the macro.

## Test plan
- Reset, then `pc_i=64'h8000_0004`, `pc_valid` pulse, zero-wait memory returning `rdata=64'h00500093_00000413` → `mem_addr=64'h8000_0000`, `inst_o=32'h00500093` at cycle 3, `fault_o=0`.
- `pc_i=64'h8000_0002` → `inst_valid` at cycle 1, `fault_o=1`, `inst_o=0`, `mem_req` never asserted.
- Memory holds `mem_gnt` low for 4 cycles, `inst_ready` low for 3 cycles in RESP → `mem_addr` and `inst_o` stable throughout; exactly one `mem_req` handshake.
- `flush` in WAIT, followed by `rvalid` two cycles later → data discarded, `inst_valid` never rises; the next fetch of `8000_0008` returns its own data.
- Response with `mem_err=1` → `fault_o=1`; a repeat fetch of the same address issues a new `mem_req`.
- With the macro defined: fetch `8000_0000`, then `8000_0004` → the second completes in 1 cycle with no `mem_req`. After `flush`, the same address misses.
